// File: rtl/sorted_ram_loader_pkg.sv
// Shared definitions for the sorted-array RAM loader and the board display mux.
// The state encoding is kept here so the LED mapping and the loader agree.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DONE,
    ERR
  } loader_state_t;

  // Wide enough for any practical DATA_W; users slice the low bits.
  localparam logic [63:0] PAD_VALUE = '1;

  // One-hot LED pattern for the board display, one LED per state.
  function automatic logic [4:0] state_leds(input loader_state_t s);
    logic [4:0] leds;
    leds = '0;
    case (s)
      IDLE:    leds = 5'b00001;
      LOAD:    leds = 5'b00010;
      PAD:     leds = 5'b00100;
      DONE:    leds = 5'b01000;
      ERR:     leds = 5'b10000;
      default: leds = '0;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/sorted_ram_loader_if.sv
// Control, RAM write port and status signals between the loader and its user.
// The loader takes the slave view; the pulse source / RAM side takes the master view.
interface sorted_ram_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);

  logic              start;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              finish;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              mem_ready;
  logic              sort_err;

  modport master (
    output start, data_valid, data_in, finish,
    input  wr_en, wr_addr, wr_data, count, busy, mem_ready, sort_err
  );

  modport slave (
    input  start, data_valid, data_in, finish,
    output wr_en, wr_addr, wr_data, count, busy, mem_ready, sort_err
  );

endinterface

// File: rtl/sorted_ram_loader.sv
// Writer side of the sorted-array RAM: accepts non-decreasing entries, writes them
// to consecutive addresses, pads the tail with all-ones and flags mem_ready.
module sorted_ram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  sorted_ram_loader_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] PAD_WORD = PAD_VALUE[DATA_W-1:0];

  loader_state_t     state, state_n;
  logic [CNT_W-1:0]  count, count_n, count_inc;
  logic [DATA_W-1:0] last, last_n;
  logic              wr_en_q, wr_en_n;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
  logic [DATA_W-1:0] wr_data_q, wr_data_n;
  logic              accept;

  assign count_inc = count + 1'b1;
  // The first entry has no predecessor, so it is always in order.
  assign accept    = (count == '0) || (bus.data_in >= last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      last      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      last      <= last_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    last_n    = last;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    if (bus.start) begin
      // start overrides everything else in the same cycle, from any state
      state_n = LOAD;
      count_n = '0;
      last_n  = '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.data_valid) begin
            if (!accept) begin
              state_n = ERR;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = count[ADDR_W-1:0];
              wr_data_n = bus.data_in;
              last_n    = bus.data_in;
              count_n   = count_inc;
              if (count_inc == FULL)
                state_n = DONE;
              else if (bus.finish)
                state_n = PAD;
            end
          end else if (bus.finish) begin
            state_n = PAD;
          end
        end
        PAD: begin
          wr_en_n   = 1'b1;
          wr_addr_n = count[ADDR_W-1:0];
          wr_data_n = PAD_WORD;
          count_n   = count_inc;
          if (count_inc == FULL)
            state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.count     = count;
  assign bus.busy      = (state == LOAD) || (state == PAD);
  assign bus.mem_ready = (state == DONE);
  assign bus.sort_err  = (state == ERR);

endmodule

// File: tb/tb_sorted_ram_loader.sv
// Bench for sorted_ram_loader: directed scenarios plus randomized entry sequences,
// checked against a transaction-level model of the sorted-load rules.
module tb_sorted_ram_loader;

  localparam int DEPTH = 32;

  logic clk;
  logic reset_n;

  sorted_ram_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  sorted_ram_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shadow RAM built from observed writes; gen tags which run wrote each word.
  int shadow     [DEPTH];
  int shadow_gen [DEPTH];
  int wcount = 0;
  int run_id = 0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      shadow[bus.wr_addr]     = int'(bus.wr_data);
      shadow_gen[bus.wr_addr] = run_id;
      wcount++;
    end
  end

  int seq[$];

  task automatic pulse(input bit st, input bit dv, input int din, input bit fin);
    bus.start      = st;
    bus.data_valid = dv;
    bus.data_in    = 8'(din);
    bus.finish     = fin;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.data_valid = 1'b0;
    bus.finish     = 1'b0;
  endtask

  task automatic run_load(input bit do_finish, input bit fin_last);
    int  acc, last, base, waited;
    bit  err, full, fin, take, ok, f;
    int  exp_ram[DEPTH];
    acc = 0; last = 0; err = 0; full = 0; fin = 0;
    pulse(1, 0, 0, 0);
    chk("start_busy", bus.busy, 1);
    chk("start_count", bus.count, 0);
    chk("start_flags", {bus.mem_ready, bus.sort_err, bus.wr_en}, 0);
    run_id++;
    base = wcount;
    for (int i = 0; i < seq.size(); i++) begin
      f    = fin_last && (i == seq.size() - 1);
      take = !err && !full && !fin;
      ok   = take && (acc == 0 || seq[i] >= last);
      pulse(0, 1, seq[i], f);
      chk("entry_wr_en", bus.wr_en, ok);
      if (ok) begin
        chk("entry_addr", bus.wr_addr, acc);
        chk("entry_data", bus.wr_data, seq[i]);
        exp_ram[acc] = seq[i];
        last = seq[i];
        acc++;
        if (acc == DEPTH) full = 1;
        else if (f) fin = 1;
      end else if (take) begin
        err = 1;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (do_finish) begin
      pulse(0, 0, 0, 1);
      if (!err && !full) fin = 1;
    end
    if (fin) begin
      for (int a = acc; a < DEPTH; a++) exp_ram[a] = 255;
      waited = 0;
      while (!bus.mem_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      chk("pad_complete", bus.mem_ready, 1);
    end
    @(negedge clk);
    if (fin || full) begin
      chk("done_ready", bus.mem_ready, 1);
      chk("done_count", bus.count, DEPTH);
      chk("done_busy", bus.busy, 0);
      chk("done_err", bus.sort_err, 0);
      chk("done_writes", wcount - base, DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
        chk("ram_written", shadow_gen[a], run_id);
        chk("ram_data", shadow[a], exp_ram[a]);
      end
      pulse(0, 1, $urandom_range(0, 255), 1);
      chk("done_ignores_input", bus.wr_en, 0);
    end else begin
      chk(err ? "err_flag" : "load_err_flag", bus.sort_err, err);
      chk("partial_count", bus.count, acc);
      chk("partial_busy", bus.busy, !err);
      chk("partial_ready", bus.mem_ready, 0);
      chk("partial_writes", wcount - base, acc);
      for (int a = 0; a < acc; a++) chk("ram_data", shadow[a], exp_ram[a]);
    end
  endtask

  int waited;
  int v;

  initial begin
    bus.start = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0; bus.finish = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin shadow[a] = -1; shadow_gen[a] = 0; end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.wr_en, bus.busy, bus.mem_ready, bus.sort_err}, 0);
    chk("rst_count", bus.count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    pulse(0, 1, 5, 1);
    chk("idle_ignores_wr", bus.wr_en, 0);
    chk("idle_busy", bus.busy, 0);

    // asynchronous reset in the middle of a load
    pulse(1, 0, 0, 0);
    pulse(0, 1, 9, 0);
    chk("pre_rst_data", bus.wr_data, 9);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_data", bus.wr_data, 0);
    chk("async_rst_addr", bus.wr_addr, 0);
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_flags", {bus.wr_en, bus.busy, bus.mem_ready, bus.sort_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    seq = '{3, 3, 7, 20};   run_load(1, 0);
    seq = '{10, 12, 11};    run_load(0, 0);
    seq.delete();
    for (int i = 0; i < DEPTH; i++) seq.push_back(i);
    run_load(0, 0);
    seq = '{2, 5};          run_load(0, 1);
    seq = '{2, 1};          run_load(0, 1);
    seq.delete();           run_load(1, 0);

    // abort while padding at count 10
    pulse(1, 0, 0, 0);
    pulse(0, 1, 4, 0);
    pulse(0, 0, 0, 1);
    waited = 0;
    while (bus.count != 10 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_reach_10", bus.count, 10);
    pulse(1, 0, 0, 0);
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_busy", bus.busy, 1);
    pulse(0, 1, 0, 0);
    chk("abort_next_wr", bus.wr_en, 1);
    chk("abort_next_addr", bus.wr_addr, 0);
    chk("abort_next_data", bus.wr_data, 0);

    for (int r = 0; r < 25; r++) begin
      int len, bad;
      len = $urandom_range(0, 34);
      bad = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 33) : -1;
      seq.delete();
      v = $urandom_range(0, 20);
      for (int i = 0; i < len; i++) begin
        if (i > 0) v = v + $urandom_range(0, 12);
        if (v > 255) v = 255;
        if (i == bad && v > 0) seq.push_back($urandom_range(0, v - 1));
        else seq.push_back(v);
      end
      run_load($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
